// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: drives N LEDs through one of four step patterns
// (blink, walk, ping-pong, count), advancing one step every DIV enabled clocks.
// Optional feature macro: LED_SEQ_PINGPONG_EN
//   defined   -> mode 2 is a bouncing ping-pong pattern
//   undefined -> mode 2 behaves as walk and the direction register is omitted
module led_pattern_sequencer #(
    parameter int N   = 4,
    parameter int DIV = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [1:0]   i_mode,
    output logic [N-1:0] o_y,
    output logic         o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_BLINK    = 2'd0,
        MODE_WALK     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_COUNT    = 2'd3
    } mode_t;

    mode_t         mode_q;
    mode_t         mode_d;
    mode_t         mode_in;
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_d;
    logic [N-1:0]  y_d;
    logic          tick_d;

`ifdef LED_SEQ_PINGPONG_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t dir_q;
    dir_t dir_d;
`endif

    assign mode_in = mode_t'(i_mode);

    // Starting pattern loaded whenever a mode is entered.
    function automatic logic [N-1:0] seed_of(input mode_t m);
        logic [N-1:0] s;
        s = '0;
        if (m == MODE_WALK || m == MODE_PINGPONG) begin
            s = N'(1);
        end
        return s;
    endfunction

    // Rotate left by one; the top LED wraps around to LED 0.
    function automatic logic [N-1:0] rotate_left(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[(i + N - 1) % N];
        end
        return r;
    endfunction

    // Registered state: mode, prescaler, LED pattern, tick and bounce direction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q  <= MODE_BLINK;
            div_cnt <= '0;
            o_y     <= '0;
            o_tick  <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            mode_q  <= mode_d;
            div_cnt <= div_d;
            o_y     <= y_d;
            o_tick  <= tick_d;
`ifdef LED_SEQ_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state: a mode change reloads the seed and beats any pending step;
    // otherwise the prescaler runs while enabled and its last count fires a step.
    always_comb begin
        mode_d = mode_q;
        div_d  = div_cnt;
        y_d    = o_y;
        tick_d = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
        dir_d  = dir_q;
`endif
        if (mode_in != mode_q) begin
            mode_d = mode_in;
            div_d  = '0;
            y_d    = seed_of(mode_in);
`ifdef LED_SEQ_PINGPONG_EN
            dir_d  = DIR_UP;
`endif
        end else if (i_en) begin
            if (div_cnt == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    MODE_BLINK: y_d = ~o_y;
                    MODE_WALK:  y_d = rotate_left(o_y);
                    MODE_PINGPONG: begin
`ifdef LED_SEQ_PINGPONG_EN
                        if (N == 1) begin
                            y_d = o_y;
                        end else begin
                            if (dir_q == DIR_UP) begin
                                y_d = o_y << 1;
                            end else begin
                                y_d = o_y >> 1;
                            end
                            if (y_d[N-1]) begin
                                dir_d = DIR_DOWN;
                            end else if (y_d[0]) begin
                                dir_d = DIR_UP;
                            end
                        end
`else
                        y_d = rotate_left(o_y);
`endif
                    end
                    MODE_COUNT: y_d = o_y + N'(1);
                    default:    y_d = o_y;
                endcase
            end else begin
                div_d = div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed bench for led_pattern_sequencer (N=4, DIV=4)
// with a step-index reference model checked every cycle plus literal checkpoints.
module tb_led_pattern_sequencer;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] y;
    logic         tick;

    int total = 0;
    int bad   = 0;

    logic model_valid = 1'b0;
    int   m_mode  = 0;
    int   m_since = 0;
    int   m_k     = 0;
    logic m_tick  = 1'b0;

    led_pattern_sequencer #(.N(N), .DIV(DIV)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_mode (mode),
        .o_y    (y),
        .o_tick (tick)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern shown after k steps in a given mode, derived directly from
    // the pattern definitions rather than from any shift/direction state.
    function automatic logic [N-1:0] model_pattern(input int md, input int k);
        int p;
        int pos;
        logic [N-1:0] r;
        r = '0;
        case (md)
            0: r = (k % 2 == 1) ? 4'b1111 : 4'b0000;
            1: r = 4'(1 << (k % N));
            2: begin
`ifdef LED_SEQ_PINGPONG_EN
                p   = k % (2 * N - 2);
                pos = (p < N) ? p : (2 * N - 2 - p);
                r   = 4'(1 << pos);
`else
                p   = 0;
                pos = 0;
                r   = 4'(1 << (k % N));
`endif
            end
            default: r = 4'(k % 16);
        endcase
        return r;
    endfunction

    // Reference model: count enabled edges since the last step or mode entry.
    always @(posedge clk) begin
        if (rst) begin
            m_mode  <= 0;
            m_since <= 0;
            m_k     <= 0;
            m_tick  <= 1'b0;
        end else if (int'(mode) != m_mode) begin
            m_mode  <= int'(mode);
            m_since <= 0;
            m_k     <= 0;
            m_tick  <= 1'b0;
        end else if (en) begin
            if (m_since + 1 == DIV) begin
                m_since <= 0;
                m_k     <= m_k + 1;
                m_tick  <= 1'b1;
            end else begin
                m_since <= m_since + 1;
                m_tick  <= 1'b0;
            end
        end else begin
            m_tick <= 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            total++;
            if (y !== model_pattern(m_mode, m_k) || tick !== m_tick) begin
                bad++;
                $display("[TB] FAIL model t=%0t y=%b tick=%b expected y=%b tick=%b",
                         $time, y, tick, model_pattern(m_mode, m_k), m_tick);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] md,
                                 input int cycles);
        rst  = r;
        en   = e;
        mode = md;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] exp_y,
                               input logic exp_tick);
        #1;
        total++;
        if (y !== exp_y || tick !== exp_tick) begin
            bad++;
            $display("[TB] FAIL %s y=%b tick=%b expected y=%b tick=%b",
                     name, y, tick, exp_y, exp_tick);
        end
    endtask

    logic [N-1:0] walk_seq [0:4];
    logic [N-1:0] pp_seq   [0:7];

    initial begin
        walk_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef LED_SEQ_PINGPONG_EN
        pp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
        pp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'd0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 2'd0, 2);
        model_valid = 1'b1;
        checkOutput("reset", 4'b0000, 1'b0);

        // Count mode full wrap, step every 4th edge
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        checkOutput("count_seed", 4'b0000, 1'b0);
        for (int s = 1; s <= 16; s++) begin
            applyStimulus(1'b0, 1'b1, 2'd3, 3);
            checkOutput("count_hold", 4'(s - 1), 1'b0);
            applyStimulus(1'b0, 1'b1, 2'd3, 1);
            checkOutput("count_step", 4'(s % 16), 1'b1);
        end

        // Pause in count mode at 0011 with one prescaler count already taken
        applyStimulus(1'b0, 1'b1, 2'd3, 12);
        checkOutput("count_at3", 4'b0011, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        applyStimulus(1'b0, 1'b0, 2'd3, 10);
        checkOutput("pause_hold", 4'b0011, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 2);
        checkOutput("resume_early", 4'b0011, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        checkOutput("resume_step", 4'b0100, 1'b1);

        // Walk mode with wrap
        applyStimulus(1'b0, 1'b1, 2'd1, 1);
        checkOutput("walk_seed", walk_seq[0], 1'b0);
        for (int s = 1; s <= 4; s++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 4);
            checkOutput("walk_step", walk_seq[s], 1'b1);
        end

        // Walk at 0100, switch to blink mid-step
        applyStimulus(1'b0, 1'b1, 2'd1, 8);
        checkOutput("walk_0100", 4'b0100, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd1, 2);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("blink_seed", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 3);
        checkOutput("blink_hold", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("blink_step", 4'b1111, 1'b1);

        // Ping-pong mode (walk when the feature is compiled out)
        applyStimulus(1'b0, 1'b1, 2'd2, 1);
        checkOutput("pp_seed", pp_seq[0], 1'b0);
        for (int s = 1; s <= 7; s++) begin
            applyStimulus(1'b0, 1'b1, 2'd2, 4);
            checkOutput("pp_step", pp_seq[s], 1'b1);
        end

        // Irregular enable pattern, checked only by the model
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, (i % 3) != 0, 2'd2, 1);
        end

        // Mode change still applies while disabled
        applyStimulus(1'b0, 1'b0, 2'd3, 1);
        checkOutput("dis_modechg3", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd1, 1);
        checkOutput("dis_modechg1", 4'b0001, 1'b0);

        // Switching walk -> mode 2 reloads the seed
        applyStimulus(1'b0, 1'b1, 2'd1, 4);
        checkOutput("walk_0010", 4'b0010, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd2, 1);
        checkOutput("reload_1to2", 4'b0001, 1'b0);

        // Reset mid-sequence in count mode at 1010
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        checkOutput("count_reseed", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 40);
        checkOutput("count_1010", 4'b1010, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd3, 1);
        checkOutput("midreset", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        checkOutput("post_reset_reload", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 3);
        checkOutput("post_reset_hold", 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1);
        checkOutput("post_reset_step", 4'b0001, 1'b1);

        applyStimulus(1'b0, 1'b0, 2'd3, 2);
        model_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
